// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 bus bundle between a master and axi4_burst_mem_slave.
// Carries all five channels; clock and reset stay outside as plain ports.
interface axi4_burst_mem_slave_if #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_BYTES  = 2,
  parameter int NUM_ID_BITS = 4
);
  localparam int DATA_W = DATA_BYTES * 8;
  localparam int ADDR_W = ADDR_BYTES * 8;

  logic                   awvalid;
  logic                   awready;
  logic [ADDR_W-1:0]      awaddr;
  logic [NUM_ID_BITS-1:0] awid;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;

  logic                   wvalid;
  logic                   wready;
  logic                   wlast;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_BYTES-1:0]  wstrb;

  logic                   bvalid;
  logic                   bready;
  logic [NUM_ID_BITS-1:0] bid;
  logic [1:0]             bresp;

  logic                   arvalid;
  logic                   arready;
  logic [ADDR_W-1:0]      araddr;
  logic [NUM_ID_BITS-1:0] arid;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;

  logic                   rvalid;
  logic                   rready;
  logic [NUM_ID_BITS-1:0] rid;
  logic [1:0]             rresp;
  logic [DATA_W-1:0]      rdata;
  logic                   rlast;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wlast, wdata, wstrb,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rresp, rdata, rlast,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wlast, wdata, wstrb,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rresp, rdata, rlast,
    output rready
  );
endinterface

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory target (FIXED/INCR/WRAP). Independent write and read
// state machines share one word-addressed array; every output is a flop.
module axi4_burst_mem_slave #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_BYTES  = 2,
  parameter int NUM_ID_BITS = 4,
  parameter int DEPTH_WORDS = 256
) (
  input logic                  aclk,
  input logic                  aresetn,
  axi4_burst_mem_slave_if.slave axi
);
  localparam int DATA_W = DATA_BYTES * 8;
  localparam int ADDR_W = ADDR_BYTES * 8;
  localparam int LSB    = $clog2(DATA_BYTES);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Address of the beat after 'addr' for the given burst shape.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    step      = ADDR_W'(1'b1) << size;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1'b1)) << size) - ADDR_W'(1'b1);
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  endfunction

  // Whole-transaction error: reserved burst, oversize beat, illegal wrap length.
  function automatic logic txn_err(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    txn_err  = (burst == BURST_RSVD) || (int'(size) > LSB) || bad_wrap;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] idx;
    idx          = addr >> LSB;
    out_of_range = (idx >= ADDR_W'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    word_idx = IDX_W'(addr >> LSB);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // ---------------- write path ----------------
  w_state_t               w_state_r, w_state_nx;
  logic                   awready_r, wready_r, bvalid_r;
  logic                   awready_nx, wready_nx, bvalid_nx;
  logic [NUM_ID_BITS-1:0] bid_r, w_id_r;
  logic [1:0]             bresp_r;
  logic [ADDR_W-1:0]      w_addr_r;
  logic [7:0]             w_len_r, w_cnt_r;
  logic [2:0]             w_size_r;
  logic [1:0]             w_burst_r;
  logic                   w_err_r, w_bad_r;
  logic                   aw_hs_s, w_hs_s, b_hs_s, w_final_s, w_oor_s, w_beat_bad_s, w_mem_en_s;

  assign aw_hs_s      = axi.awvalid & awready_r;
  assign w_hs_s       = axi.wvalid & wready_r;
  assign b_hs_s       = bvalid_r & axi.bready;
  assign w_final_s    = (w_cnt_r == 8'd0);
  assign w_oor_s      = out_of_range(w_addr_r);
  assign w_beat_bad_s = w_err_r | w_oor_s | (axi.wlast != w_final_s);
  assign w_mem_en_s   = w_hs_s & ~w_err_r & ~w_oor_s;

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) w_state_r <= W_IDLE;
    else          w_state_r <= w_state_nx;

  // Write FSM next state; the beat counter alone ends the data phase.
  always_comb begin
    w_state_nx = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_state_nx = W_DATA; else w_state_nx = W_IDLE;
      W_DATA:  if (w_hs_s && w_final_s) w_state_nx = W_RESP; else w_state_nx = W_DATA;
      W_RESP:  if (b_hs_s) w_state_nx = W_IDLE; else w_state_nx = W_RESP;
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write handshake outputs decoded from the upcoming state, then registered.
  always_comb begin
    awready_nx = 1'b0;
    wready_nx  = 1'b0;
    bvalid_nx  = 1'b0;
    case (w_state_nx)
      W_IDLE:  awready_nx = 1'b1;
      W_DATA:  wready_nx  = 1'b1;
      W_RESP:  bvalid_nx  = 1'b1;
      default: awready_nx = 1'b0;
    endcase
  end

  // Write channel output flops; B fields captured on the final data beat.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= RESP_OKAY;
    end else begin
      awready_r <= awready_nx;
      wready_r  <= wready_nx;
      bvalid_r  <= bvalid_nx;
      if (w_hs_s && w_final_s) begin
        bid_r   <= w_id_r;
        bresp_r <= (w_bad_r | w_beat_bad_s) ? RESP_SLVERR : RESP_OKAY;
      end
    end

  // Write burst context: latched on AW, stepped on every accepted W beat.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_addr_r <= '0; w_id_r <= '0; w_len_r <= 8'd0; w_cnt_r <= 8'd0;
      w_size_r <= 3'd0; w_burst_r <= 2'd0; w_err_r <= 1'b0; w_bad_r <= 1'b0;
    end else if (aw_hs_s) begin
      w_addr_r  <= axi.awaddr;
      w_id_r    <= axi.awid;
      w_len_r   <= axi.awlen;
      w_cnt_r   <= axi.awlen;
      w_size_r  <= axi.awsize;
      w_burst_r <= axi.awburst;
      w_err_r   <= txn_err(axi.awlen, axi.awsize, axi.awburst);
      w_bad_r   <= 1'b0;
    end else if (w_hs_s) begin
      w_addr_r <= next_addr(w_addr_r, w_len_r, w_size_r, w_burst_r);
      w_cnt_r  <= w_cnt_r - 8'd1;
      w_bad_r  <= w_bad_r | w_beat_bad_s;
    end

  // Byte-lane memory write; the array itself is never reset.
  always_ff @(posedge aclk)
    if (w_mem_en_s)
      for (int b = 0; b < DATA_BYTES; b++)
        if (axi.wstrb[b]) mem[word_idx(w_addr_r)][b*8 +: 8] <= axi.wdata[b*8 +: 8];

  // ---------------- read path ----------------
  r_state_t               r_state_r, r_state_nx;
  logic                   arready_r, rvalid_r, rlast_r;
  logic                   arready_nx, rvalid_nx;
  logic [NUM_ID_BITS-1:0] rid_r;
  logic [1:0]             rresp_r;
  logic [DATA_W-1:0]      rdata_r, rd_word_s;
  logic [ADDR_W-1:0]      r_addr_r, rd_addr_s;
  logic [7:0]             r_len_r, r_cnt_r;
  logic [2:0]             r_size_r;
  logic [1:0]             r_burst_r;
  logic                   r_err_r, rd_err_s, rd_bad_s;
  logic                   ar_hs_s, r_hs_s, r_adv_s;

  assign ar_hs_s = axi.arvalid & arready_r;
  assign r_hs_s  = rvalid_r & axi.rready;
  assign r_adv_s = r_hs_s & (r_cnt_r != 8'd0);

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state_r <= R_IDLE;
    else          r_state_r <= r_state_nx;

  // Read FSM next state: leave data phase on the rlast handshake.
  always_comb begin
    r_state_nx = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_nx = R_DATA; else r_state_nx = R_IDLE;
      R_DATA:  if (r_hs_s && (r_cnt_r == 8'd0)) r_state_nx = R_IDLE; else r_state_nx = R_DATA;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read handshake outputs decoded from the upcoming state.
  always_comb begin
    arready_nx = 1'b0;
    rvalid_nx  = 1'b0;
    case (r_state_nx)
      R_IDLE:  arready_nx = 1'b1;
      R_DATA:  rvalid_nx  = 1'b1;
      default: arready_nx = 1'b0;
    endcase
  end

  // Address and data of the beat to present next (beat 0 on AR, else successor).
  always_comb begin
    rd_addr_s = r_addr_r;
    rd_err_s  = r_err_r;
    if (ar_hs_s) begin
      rd_addr_s = axi.araddr;
      rd_err_s  = txn_err(axi.arlen, axi.arsize, axi.arburst);
    end else begin
      rd_addr_s = next_addr(r_addr_r, r_len_r, r_size_r, r_burst_r);
      rd_err_s  = r_err_r;
    end
    rd_bad_s = rd_err_s | out_of_range(rd_addr_s);
    if (rd_bad_s) rd_word_s = '0;
    else          rd_word_s = mem[word_idx(rd_addr_s)];
  end

  // Read burst context: latched on AR, stepped on every non-final R handshake.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_addr_r <= '0; r_len_r <= 8'd0; r_cnt_r <= 8'd0;
      r_size_r <= 3'd0; r_burst_r <= 2'd0; r_err_r <= 1'b0;
    end else if (ar_hs_s) begin
      r_addr_r  <= axi.araddr;
      r_len_r   <= axi.arlen;
      r_cnt_r   <= axi.arlen;
      r_size_r  <= axi.arsize;
      r_burst_r <= axi.arburst;
      r_err_r   <= rd_err_s;
    end else if (r_adv_s) begin
      r_addr_r <= rd_addr_s;
      r_cnt_r  <= r_cnt_r - 8'd1;
    end

  // Read channel output flops; R payload only moves when a new beat is loaded.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rid_r     <= '0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
      rlast_r   <= 1'b0;
    end else begin
      arready_r <= arready_nx;
      rvalid_r  <= rvalid_nx;
      if (ar_hs_s) rid_r <= axi.arid;
      if (ar_hs_s || r_adv_s) begin
        rdata_r <= rd_word_s;
        rresp_r <= rd_bad_s ? RESP_SLVERR : RESP_OKAY;
        rlast_r <= ar_hs_s ? (axi.arlen == 8'd0) : (r_cnt_r == 8'd1);
      end
    end

  assign axi.awready = awready_r;
  assign axi.wready  = wready_r;
  assign axi.bvalid  = bvalid_r;
  assign axi.bid     = bid_r;
  assign axi.bresp   = bresp_r;
  assign axi.arready = arready_r;
  assign axi.rvalid  = rvalid_r;
  assign axi.rid     = rid_r;
  assign axi.rresp   = rresp_r;
  assign axi.rdata   = rdata_r;
  assign axi.rlast   = rlast_r;
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Self-checking bench for axi4_burst_mem_slave: a table of read bursts with
// hand-computed words, plus directed write, error, concurrency and reset cases.
module tb_axi4_burst_mem_slave;
  localparam int LIM = 100;

  logic aclk;
  logic aresetn;
  int   checks;
  int   failures;

  axi4_burst_mem_slave_if #(.DATA_BYTES(4), .ADDR_BYTES(2), .NUM_ID_BITS(4)) axi ();

  axi4_burst_mem_slave #(.DATA_BYTES(4), .ADDR_BYTES(2), .NUM_ID_BITS(4), .DEPTH_WORDS(256)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .axi    (axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       resp;
    logic [3:0][31:0] d;
  } rvec_t;

  rvec_t       tbl [10];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rexp [16];
  logic [31:0] model [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  function automatic rvec_t mk(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
      input logic [1:0] b, input logic [1:0] r, input logic [31:0] d0, input logic [31:0] d1,
      input logic [31:0] d2, input logic [31:0] d3);
    rvec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.resp = r;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    return v;
  endfunction

  // Full write burst: AW, W beats from wd/ws (wlast on beat last_beat), then B.
  task automatic wr_burst(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst, input int last_beat,
      input logic [1:0] exp_resp, input bit stall, input string nm);
    int to;
    logic [15:0] a;
    @(negedge aclk);
    axi.awvalid = 1'b1; axi.awaddr = addr; axi.awid = id;
    axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    to = 0;
    while (!axi.awready && to < LIM) begin @(negedge aclk); to++; end
    chk({nm, "_aw_wait"}, 32'(to < LIM), 32'd1);
    @(negedge aclk);
    axi.awvalid = 1'b0;
    chk({nm, "_awready_low"}, 32'(axi.awready), 32'd0);
    chk({nm, "_wready_high"}, 32'(axi.wready), 32'd1);
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      while (stall && ($urandom_range(0, 2) == 0)) begin axi.wvalid = 1'b0; @(negedge aclk); end
      axi.wvalid = 1'b1; axi.wdata = wd[b]; axi.wstrb = ws[b]; axi.wlast = (b == last_beat);
      to = 0;
      while (!axi.wready && to < LIM) begin @(negedge aclk); to++; end
      chk({nm, "_w_wait"}, 32'(to < LIM), 32'd1);
      if (a < 16'h0400)
        for (int k = 0; k < 4; k++)
          if (ws[b][k]) model[a[9:2]][k*8 +: 8] = wd[b][k*8 +: 8];
      if (burst != 2'd0) a = a + (16'd1 << size);
      @(negedge aclk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    chk({nm, "_wready_low"}, 32'(axi.wready), 32'd0);
    to = 0;
    while (!axi.bvalid && to < LIM) begin @(negedge aclk); to++; end
    chk({nm, "_b_wait"}, 32'(to < LIM), 32'd1);
    if (stall) begin
      repeat (2) @(negedge aclk);
      chk({nm, "_bvalid_hold"}, 32'(axi.bvalid), 32'd1);
    end
    chk({nm, "_bid"}, 32'(axi.bid), 32'(id));
    chk({nm, "_bresp"}, 32'(axi.bresp), 32'(exp_resp));
    axi.bready = 1'b1;
    @(negedge aclk);
    axi.bready = 1'b0;
    chk({nm, "_bvalid_done"}, 32'(axi.bvalid), 32'd0);
    chk({nm, "_awready_back"}, 32'(axi.awready), 32'd1);
  endtask

  // Full read burst; beat b is compared against rexp[b].
  task automatic rd_burst(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
      input bit rnd, input string nm);
    int to;
    bit got;
    bit prev_v;
    logic [31:0] held;
    @(negedge aclk);
    axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id;
    axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    to = 0;
    while (!axi.arready && to < LIM) begin @(negedge aclk); to++; end
    chk({nm, "_ar_wait"}, 32'(to < LIM), 32'd1);
    @(negedge aclk);
    axi.arvalid = 1'b0;
    chk({nm, "_arready_low"}, 32'(axi.arready), 32'd0);
    chk({nm, "_rvalid_first"}, 32'(axi.rvalid), 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      got = 1'b0; to = 0;
      while (!got && to < LIM) begin
        axi.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axi.rvalid && axi.rready) begin
          chk($sformatf("%s_rdata%0d", nm, b), axi.rdata, rexp[b]);
          chk($sformatf("%s_rresp%0d", nm, b), 32'(axi.rresp), 32'(exp_resp));
          chk($sformatf("%s_rlast%0d", nm, b), 32'(axi.rlast), 32'(b == int'(len)));
          chk($sformatf("%s_rid%0d", nm, b), 32'(axi.rid), 32'(id));
          got = 1'b1;
        end else begin
          prev_v = axi.rvalid;
          held   = axi.rdata;
          @(negedge aclk);
          to++;
          if (prev_v) chk({nm, "_rdata_hold"}, axi.rdata, held);
        end
      end
      chk({nm, "_beat_wait"}, 32'(got), 32'd1);
      if (got) @(negedge aclk);
    end
    axi.rready = 1'b0;
    chk({nm, "_arready_back"}, 32'(axi.arready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    aresetn = 1'b0;
    axi.awvalid = 1'b0; axi.awaddr = 16'h0; axi.awid = 4'h0; axi.awlen = 8'h0;
    axi.awsize = 3'd0; axi.awburst = 2'd0;
    axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.wdata = 32'h0; axi.wstrb = 4'h0;
    axi.bready = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = 16'h0; axi.arid = 4'h0; axi.arlen = 8'h0;
    axi.arsize = 3'd0; axi.arburst = 2'd0;
    axi.rready = 1'b0;

    // Reset state and the first edge after release.
    repeat (2) @(negedge aclk);
    chk("rst_awready", 32'(axi.awready), 32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd0);
    chk("rst_outs", {axi.wready, axi.bvalid, axi.rvalid, axi.rlast, axi.bid, axi.rid,
                     axi.bresp, axi.rresp}, 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);
    #2 aresetn = 1'b1;
    #1 chk("rel_awready_pre", 32'(axi.awready), 32'd0);
    @(negedge aclk);
    chk("rel_awready", 32'(axi.awready), 32'd1);
    chk("rel_arready", 32'(axi.arready), 32'd1);

    // Preload words 0..15 with their index.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    wr_burst(16'h0000, 4'h1, 8'd15, 3'd2, 2'd1, 15, 2'b00, 1'b0, "preload");

    // Read table: hand-computed beats against the preloaded words.
    tbl[0] = mk(16'h0000, 8'd3, 3'd2, 2'd1, 2'b00, 32'd0, 32'd1, 32'd2, 32'd3);
    tbl[1] = mk(16'h0018, 8'd3, 3'd2, 2'd2, 2'b00, 32'd6, 32'd7, 32'd4, 32'd5);
    tbl[2] = mk(16'h0018, 8'd2, 3'd2, 2'd2, 2'b10, 32'd0, 32'd0, 32'd0, 32'd0);
    tbl[3] = mk(16'h0008, 8'd2, 3'd2, 2'd0, 2'b00, 32'd2, 32'd2, 32'd2, 32'd0);
    tbl[4] = mk(16'h000C, 8'd1, 3'd2, 2'd2, 2'b00, 32'd3, 32'd2, 32'd0, 32'd0);
    tbl[5] = mk(16'h0000, 8'd1, 3'd3, 2'd1, 2'b10, 32'd0, 32'd0, 32'd0, 32'd0);
    tbl[6] = mk(16'h0000, 8'd0, 3'd2, 2'd3, 2'b10, 32'd0, 32'd0, 32'd0, 32'd0);
    tbl[7] = mk(16'h0400, 8'd0, 3'd2, 2'd1, 2'b10, 32'd0, 32'd0, 32'd0, 32'd0);
    tbl[8] = mk(16'h0004, 8'd1, 3'd0, 2'd1, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0);
    tbl[9] = mk(16'h0004, 8'd3, 3'd2, 2'd2, 2'b00, 32'd1, 32'd2, 32'd3, 32'd0);
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < 4; b++) rexp[b] = tbl[i].d[b];
      rd_burst(tbl[i].addr, 4'(i), tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].resp, 1'b0,
               $sformatf("tbl%0d", i));
    end

    // INCR write then read back.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    wr_burst(16'h0010, 4'h2, 8'd3, 3'd2, 2'd1, 3, 2'b00, 1'b0, "incr_wr");
    for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + 32'(i);
    rd_burst(16'h0010, 4'h2, 8'd3, 3'd2, 2'd1, 2'b00, 1'b0, "incr_rd");

    // FIXED write with per-beat strobes onto a cleared word.
    wd[0] = 32'h0; ws[0] = 4'hF;
    wr_burst(16'h0020, 4'h3, 8'd0, 3'd2, 2'd1, 0, 2'b00, 1'b0, "clr8");
    wd[0] = 32'h11111111; ws[0] = 4'h1;
    wd[1] = 32'h22222222; ws[1] = 4'h2;
    wd[2] = 32'h44444444; ws[2] = 4'h4;
    wr_burst(16'h0020, 4'h3, 8'd2, 3'd2, 2'd0, 2, 2'b00, 1'b0, "fixed_wr");
    rexp[0] = 32'h00442211;
    rd_burst(16'h0020, 4'h3, 8'd0, 3'd2, 2'd1, 2'b00, 1'b0, "fixed_rd");

    // Burst whose last beat lands on word DEPTH_WORDS.
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    wr_burst(16'h03F8, 4'h4, 8'd2, 3'd2, 2'd1, 2, 2'b10, 1'b0, "oor_wr");
    rexp[0] = 32'hB0; rexp[1] = 32'hB1;
    rd_burst(16'h03F8, 4'h4, 8'd1, 3'd2, 2'd1, 2'b00, 1'b0, "oor_rd");

    // Early wlast on beat 1 of 4: all four beats still land.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
    wr_burst(16'h0040, 4'h6, 8'd3, 3'd2, 2'd1, 1, 2'b10, 1'b0, "early_wr");
    for (int i = 0; i < 4; i++) rexp[i] = 32'hC0 + 32'(i);
    rd_burst(16'h0040, 4'h6, 8'd3, 3'd2, 2'd1, 2'b00, 1'b0, "early_rd");

    // Concurrent 16-beat write and read with random stalls.
    for (int i = 0; i < 16; i++) begin
      wd[i] = 32'hD0000000 + 32'(i); ws[i] = 4'hF; rexp[i] = model[i];
    end
    fork
      wr_burst(16'h0100, 4'h5, 8'd15, 3'd2, 2'd1, 15, 2'b00, 1'b1, "conc_wr");
      rd_burst(16'h0000, 4'hA, 8'd15, 3'd2, 2'd1, 2'b00, 1'b1, "conc_rd");
    join
    for (int i = 0; i < 16; i++) rexp[i] = 32'hD0000000 + 32'(i);
    rd_burst(16'h0100, 4'h7, 8'd15, 3'd2, 2'd1, 2'b00, 1'b0, "conc_chk");

    // Reset during beat 2 of an 8-beat read.
    @(negedge aclk);
    axi.arvalid = 1'b1; axi.araddr = 16'h0000; axi.arid = 4'h3;
    axi.arlen = 8'd7; axi.arsize = 3'd2; axi.arburst = 2'd1;
    begin
      int to;
      to = 0;
      while (!axi.arready && to < LIM) begin @(negedge aclk); to++; end
      chk("mid_ar_wait", 32'(to < LIM), 32'd1);
    end
    @(negedge aclk);
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    repeat (2) @(negedge aclk);
    chk("mid_beat2", axi.rdata, 32'd2);
    #2 aresetn = 1'b0;
    #1 chk("mid_rvalid_drop", 32'(axi.rvalid), 32'd0);
    chk("mid_rst_outs", {axi.arready, axi.awready, axi.rlast, axi.bvalid}, 32'd0);
    chk("mid_rst_rdata", axi.rdata, 32'd0);
    axi.rready = 1'b0;
    @(negedge aclk);
    #2 aresetn = 1'b1;
    #1 chk("mid_arready_pre", 32'(axi.arready), 32'd0);
    @(negedge aclk);
    chk("mid_arready_post", 32'(axi.arready), 32'd1);
    chk("mid_rvalid_post", 32'(axi.rvalid), 32'd0);
    rexp[0] = 32'd0; rexp[1] = 32'd1;
    rd_burst(16'h0000, 4'h9, 8'd1, 3'd2, 2'd1, 2'b00, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
